// File: rtl/fft_seq_pkg.sv
// Shared constants, state encodings and helpers for the 16-point FFT bus sequencer.
// The FFT_SEQ_BITREV_EN build option uses bitrev4 below to reorder bin readout.
package fft_seq_pkg;

  localparam logic [13:0] WR_ADDR_DEF = 14'h0A0;
  localparam logic [13:0] RD_BASE_DEF = 14'h088;

  localparam logic [1:0] PER_WE_WR = 2'b11;
  localparam logic [1:0] PER_WE_RD = 2'b00;

  // Plain constants keep the encoding visible to older tooling and netlist viewers.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_RD_OUT = 3'd4;

  function automatic logic [3:0] bitrev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

// File: rtl/fft_seq_rd_addr.sv
// Maps a result word index (re/im interleaved) to the FFT peripheral read address.
// With FFT_SEQ_BITREV_EN defined, the bin index is bit-reversed so bins come out in natural order.
module fft_seq_rd_addr
  import fft_seq_pkg::*;
#(
  parameter logic [13:0] RD_BASE = RD_BASE_DEF
) (
  input  logic [4:0]  word_idx,
  output logic [13:0] rd_addr
);

`ifdef FFT_SEQ_BITREV_EN
  always_comb begin
    rd_addr = RD_BASE + {8'b0, bitrev4(word_idx[4:1]), word_idx[0]};
  end
`else
  always_comb begin
    rd_addr = RD_BASE + {9'b0, word_idx};
  end
`endif

endmodule

// File: rtl/fft_seq_ctrl.sv
// Bus-master sequencer: streams a 16-sample frame into the FFT, waits for settling, then
// reads the 32 result words out on a valid/ready stream. Build option: FFT_SEQ_BITREV_EN.
module fft_seq_ctrl
  import fft_seq_pkg::*;
#(
  parameter logic [13:0] WR_ADDR    = WR_ADDR_DEF,
  parameter logic [13:0] RD_BASE    = RD_BASE_DEF,
  parameter int          N_PTS      = 16,
  parameter int          SETTLE_CYC = 2
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  localparam logic [4:0] N_PTS_C     = 5'(N_PTS);
  localparam logic [4:0] LAST_WORD   = 5'(2 * N_PTS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic [2:0]  state;
  logic [4:0]  smp_cnt;
  logic [4:0]  word_cnt;
  logic [3:0]  settle_cnt;
  logic [4:0]  rd_idx;
  logic [13:0] rd_addr;
  logic        s_hs;
  logic        m_hs;

  assign busy    = (state != ST_IDLE);
  assign s_ready = (state == ST_LOAD) && (smp_cnt < N_PTS_C);
  assign m_valid = (state == ST_RD_OUT);
  assign m_last  = m_valid && (word_cnt == LAST_WORD);
  assign s_hs    = s_valid & s_ready;
  assign m_hs    = m_valid & m_ready;
  assign done    = m_hs & m_last;

  // Bus outputs are registered, so the address for the next read is prepared one state early.
  assign rd_idx = (state == ST_RD_OUT) ? word_cnt + 5'd1 : word_cnt;

  fft_seq_rd_addr #(
    .RD_BASE (RD_BASE)
  ) u_rd_addr (
    .word_idx (rd_idx),
    .rd_addr  (rd_addr)
  );

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state      <= ST_IDLE;
      smp_cnt    <= '0;
      word_cnt   <= '0;
      settle_cnt <= '0;
      m_data     <= '0;
      per_addr   <= '0;
      per_din    <= '0;
      per_en     <= 1'b0;
      per_we     <= PER_WE_RD;
    end else begin
      per_en <= 1'b0;
      per_we <= PER_WE_RD;
      case (state)
        ST_IDLE: begin
          per_addr <= '0;
          if (start) begin
            state    <= ST_LOAD;
            smp_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (s_hs) begin
            per_en   <= 1'b1;
            per_we   <= PER_WE_WR;
            per_addr <= WR_ADDR;
            per_din  <= s_data;
            smp_cnt  <= smp_cnt + 5'd1;
          end else if (smp_cnt == N_PTS_C) begin
            // The final write is on the bus this cycle; settling starts after it.
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state    <= ST_RD_REQ;
            per_en   <= 1'b1;
            per_addr <= rd_addr;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_RD_REQ: begin
          m_data <= per_dout;
          state  <= ST_RD_OUT;
        end
        ST_RD_OUT: begin
          if (m_hs) begin
            if (word_cnt == LAST_WORD) begin
              state    <= ST_IDLE;
              per_addr <= '0;
            end else begin
              word_cnt <= word_cnt + 5'd1;
              state    <= ST_RD_REQ;
              per_en   <= 1'b1;
              per_addr <= rd_addr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: stimulus pushes expected bus writes, read addresses and
// result words; a negedge monitor pops and compares them as the DUT presents them.
module tb_fft_seq_ctrl;

  logic        mclk;
  logic        puc_rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } res_t;

  logic [15:0] wr_exp[$];
  logic [13:0] ra_exp[$];
  res_t        rd_exp[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int last_wr_cyc = 0;
  int wr_seen = 0;
  int mon_words = 0;
  int done_cnt = 0;
  int mon_stall = 0;

  fft_seq_ctrl dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout)
  );

  // FFT model: each result word simply reflects the address it was read from.
  assign per_dout = {2'b00, per_addr};

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [13:0] exp_rd_addr(input int k);
    int b;
    b = k / 2;
`ifdef FFT_SEQ_BITREV_EN
    b = ((b & 1) << 3) | ((b & 2) << 1) | ((b & 4) >> 1) | ((b & 8) >> 3);
`endif
    return 14'(14'h088 + 2 * b + (k % 2));
  endfunction

  // Monitor: every bus cycle and every output handshake is matched against the queues.
  always @(negedge mclk) begin
    cyc_cnt++;
    if (puc_rst_n) begin
      if (per_en) begin
        if (per_we != 2'b00) begin
          if (wr_exp.size() == 0) begin
            fail("unexpected_write");
          end else begin
            chk("wr_din", per_din, wr_exp.pop_front());
            chk("wr_addr", per_addr, 14'h0A0);
            chk("wr_we", per_we, 2'b11);
          end
          wr_seen++;
          last_wr_cyc = cyc_cnt;
        end else begin
          if (ra_exp.size() == 0) begin
            fail("unexpected_read");
          end else begin
            if (ra_exp.size() == 32) chk("settle_gap", 32'(cyc_cnt - last_wr_cyc), 32'd3);
            chk("rd_addr", per_addr, ra_exp.pop_front());
          end
        end
      end
      if (m_valid && m_ready) begin
        if (rd_exp.size() == 0) begin
          fail("unexpected_result");
        end else begin
          res_t e;
          e = rd_exp.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
          chk("done", done, e.last);
          if (e.last) chk("busy_at_done", busy, 1'b1);
        end
        mon_words++;
      end else if (m_valid) begin
        mon_stall++;
        if (rd_exp.size() != 0) chk("stall_m_data", m_data, rd_exp[0].data);
        chk("stall_per_en", per_en, 1'b0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_per_addr"}, per_addr, 0);
    chk({tag, "_per_din"}, per_din, 0);
    chk({tag, "_per_en"}, per_en, 0);
    chk({tag, "_per_we"}, per_we, 0);
  endtask

  task automatic prime_expect();
    wr_exp.delete();
    ra_exp.delete();
    rd_exp.delete();
    for (int k = 0; k < 32; k++) begin
      ra_exp.push_back(exp_rd_addr(k));
      rd_exp.push_back('{data: {2'b00, exp_rd_addr(k)}, last: (k == 31)});
    end
    wr_seen = 0;
    mon_words = 0;
    done_cnt = 0;
    mon_stall = 0;
    m_ready = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] first, input int n);
    int  i = 0;
    int  cyc = 0;
    bit  hs;
    @(posedge mclk); #1;
    start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = first;
    while (i < n && cyc < 100) begin
      @(negedge mclk);
      cyc++;
      hs = s_valid && s_ready;
      if (hs) wr_exp.push_back(s_data);
      @(posedge mclk); #1;
      if (hs) begin
        i++;
        s_data = first + 16'(i);
      end
    end
    s_valid = 1'b0;
    if (i < n) fail("load_timeout");
    if (n == 16) begin
      chk("load_cycles", cyc, 16);
      chk("s_ready_after_load", s_ready, 1'b0);
    end
  endtask

  task automatic checkOutput(input int stall_word, input int stall_len, input bit poke);
    int cyc = 0;
    int stalled = 0;
    bit busy_early = 0;
    bit poked = 0;
    while (mon_words < 32 && cyc < 600) begin
      @(posedge mclk); #1;
      cyc++;
      start = 1'b0;
      if (mon_words < 32 && !busy) busy_early = 1'b1;
      if (m_valid && mon_words == stall_word && stalled < stall_len) begin
        m_ready = 1'b0;
        stalled++;
      end else begin
        m_ready = 1'b1;
      end
      if (poke && !poked && m_valid && mon_words == 10) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    if (mon_words < 32) fail("readout_timeout");
    chk("busy_fall", busy, 1'b0);
    chk("busy_during_readout", busy_early, 1'b0);
    chk("word_count", mon_words, 32);
    chk("write_count", wr_seen, 16);
    chk("done_count", done_cnt, 1);
    chk("stall_cycles", mon_stall, stall_len);
    chk("results_left", rd_exp.size(), 0);
    chk("reads_left", ra_exp.size(), 0);
    repeat (3) @(posedge mclk);
    #1;
    chk("idle_after_frame", busy, 1'b0);
  endtask

  task automatic run_frame(input logic [15:0] first, input int stall_word, input int stall_len,
                           input bit poke);
    prime_expect();
    applyStimulus(first, 16);
    checkOutput(stall_word, stall_len, poke);
  endtask

  initial begin
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    puc_rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    #10;
    puc_rst_n = 1'b1;

    run_frame(16'h0001, -1, 0, 1'b0);
    run_frame(16'h0100, 3, 5, 1'b1);

    prime_expect();
    applyStimulus(16'h0200, 7);
    #1;
    puc_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    wr_exp.delete();
    ra_exp.delete();
    rd_exp.delete();
    @(posedge mclk);
    #3;
    puc_rst_n = 1'b1;
    run_frame(16'h0300, -1, 0, 1'b0);

    repeat (2) @(posedge mclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
